// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer:
// state encoding, supported opcodes and control-word field positions.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b000100;

  localparam logic [2:0] ALU_MUL = 3'b101;

  localparam int ERF_BIT = 22;
  localparam int CS_BIT  = 2;
  localparam int WR_BIT  = 1;
  localparam int ALU_LSB = 3;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; sole owner of the PC.
// Optional retire counter output enabled by CPU_SEQ_RETIRE_CNT_EN.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  illegal,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  input  logic [31:0]           ctl_word,
  output logic [31:0]           ctl_q,
  output logic                  alu_start,
  input  logic                  alu_done,
  output logic                  dmem_cs,
  output logic                  dmem_wr,
  input  logic                  dmem_ack,
  output logic                  rf_we
`ifdef CPU_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0]           retire_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_t state;
  logic   stop_pending;
  logic   stop_any;
  logic   exec_done;

  // A stop arriving on the very cycle it could be honoured is taken immediately.
  assign stop_any  = stop_pending | stop;
  assign exec_done = (ctl_q[ALU_LSB +: 3] != ALU_MUL) || alu_done;

  // Every strobe is registered on the transition into the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
      pc           <= PC_INIT;
      instr        <= '0;
      ctl_q        <= '0;
      busy         <= 1'b0;
      illegal      <= 1'b0;
      imem_req     <= 1'b0;
      alu_start    <= 1'b0;
      dmem_cs      <= 1'b0;
      dmem_wr      <= 1'b0;
      rf_we        <= 1'b0;
    end else begin
      if (stop) stop_pending <= 1'b1;
      illegal   <= 1'b0;
      alu_start <= 1'b0;
      rf_we     <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            pc       <= PC_INIT;
            busy     <= 1'b1;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end

        FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            illegal  <= !op_legal(imem_rdata[31:26]);
            state    <= DECODE;
          end
        end

        DECODE: begin
          if (op_legal(instr[31:26])) begin
            ctl_q     <= ctl_word;
            alu_start <= 1'b1;
            state     <= EXEC;
          end else begin
            pc <= pc + PC_STEP;
            if (stop_any) begin
              stop_pending <= 1'b0;
              busy         <= 1'b0;
              state        <= IDLE;
            end else begin
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end

        EXEC: begin
          if (exec_done) begin
            if (ctl_q[CS_BIT]) begin
              dmem_cs <= 1'b1;
              dmem_wr <= ctl_q[WR_BIT];
              state   <= MEM;
            end else begin
              rf_we <= ctl_q[ERF_BIT];
              state <= WB;
            end
          end
        end

        MEM: begin
          if (dmem_ack) begin
            dmem_cs <= 1'b0;
            dmem_wr <= 1'b0;
            rf_we   <= ctl_q[ERF_BIT];
            state   <= WB;
          end
        end

        WB: begin
          pc <= pc + PC_STEP;
          if (stop_any) begin
            stop_pending <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end

        default: begin
          busy     <= 1'b0;
          imem_req <= 1'b0;
          dmem_cs  <= 1'b0;
          dmem_wr  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef CPU_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (state == WB) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed cases then randomized
// instructions, checked against a per-instruction phase timeline model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, illegal, imem_req, alu_start, dmem_cs, dmem_wr, rf_we;
  logic [7:0]  pc;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] ctl_word = '0;
  logic [31:0] ctl_q;
  logic        alu_done = 1'b0;
  logic        dmem_ack = 1'b0;
`ifdef CPU_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_pc = 8'h00;
  int unsigned exp_retired = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.ADDR_WIDTH(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .busy(busy), .illegal(illegal), .pc(pc),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .ctl_word(ctl_word), .ctl_q(ctl_q),
    .alu_start(alu_start), .alu_done(alu_done),
    .dmem_cs(dmem_cs), .dmem_wr(dmem_wr), .dmem_ack(dmem_ack),
    .rf_we(rf_we)
`ifdef CPU_SEQ_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  // {busy, imem_req, illegal, alu_start, dmem_cs, dmem_wr, rf_we}
  function automatic logic [31:0] obs_vec();
    return {25'd0, busy, imem_req, illegal, alu_start, dmem_cs, dmem_wr, rf_we};
  endfunction

  function automatic logic [31:0] mk_vec(input bit b, ir, il, as, cs, wr, we);
    return {25'd0, b, ir, il, as, cs, wr, we};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    chk("idle_before_start", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));
    start = 1'b1;
    step();
    start = 1'b0;
    exp_pc = 8'h00;
    $display("[TB] start -> busy=%0b", busy);
  endtask

  // Runs one instruction from its first FETCH cycle, checking every cycle.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] ctl,
                           input int idly, input int adly, input int ddly,
                           input bit stop_mem);
    bit legal = (ins[31:26] == 6'd2) || (ins[31:26] == 6'd3) || (ins[31:26] == 6'd4);
    bit mul   = (ctl[5:3] == 3'b101);
    bit use_mem = ctl[2];
    int exec_n = mul ? adly + 1 : 1;
    int cycles = 0;
    for (int k = 0; k <= idly; k++) begin
      imem_rdata = ins;
      imem_ack   = (k == idly);
      chk("fetch_strobes", obs_vec(), mk_vec(1, 1, 0, 0, 0, 0, 0));
      chk("fetch_pc", {24'd0, pc}, {24'd0, exp_pc});
      step(); cycles++;
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    ctl_word   = ctl;
    chk("decode_strobes", obs_vec(), mk_vec(1, 0, !legal, 0, 0, 0, 0));
    chk("decode_instr", instr, ins);
    step(); cycles++;
    ctl_word = $urandom;
    if (!legal) begin
      exp_pc = exp_pc + 8'd4;
      $display("[TB] instr %h illegal, %0d cycles, next pc %h", ins, cycles, exp_pc);
      return;
    end
    for (int e = 0; e < exec_n; e++) begin
      alu_done = mul ? (e == adly) : 1'($urandom_range(0, 1));
      chk("exec_strobes", obs_vec(), mk_vec(1, 0, 0, e == 0, 0, 0, 0));
      chk("exec_ctl_q", ctl_q, ctl);
      step(); cycles++;
    end
    alu_done = 1'b0;
    if (use_mem) begin
      for (int m = 0; m <= ddly; m++) begin
        dmem_ack = (m == ddly);
        stop     = stop_mem && (m == 0);
        chk("mem_strobes", obs_vec(), mk_vec(1, 0, 0, 0, 1, ctl[1], 0));
        step(); cycles++;
      end
      dmem_ack = 1'b0;
      stop     = 1'b0;
    end
    chk("wb_strobes", obs_vec(), mk_vec(1, 0, 0, 0, 0, 0, ctl[22]));
    chk("wb_ctl_q", ctl_q, ctl);
    chk("wb_pc", {24'd0, pc}, {24'd0, exp_pc});
    step(); cycles++;
    exp_pc = exp_pc + 8'd4;
    exp_retired++;
    $display("[TB] instr %h ctl %h retired, %0d cycles, next pc %h", ins, ctl, cycles, exp_pc);
  endtask

  initial begin
    logic [31:0] ins, ctl;
    logic [7:0]  prev_pc;
    logic [5:0]  op;

    #2;
    chk("reset_strobes", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));
    chk("reset_pc", {24'd0, pc}, 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_ctl_q", ctl_q, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("idle_hold", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));

    do_start();
    run_instr(32'h0822_1820, 32'h0040_0008, 0, 0, 0, 0);  // ADD
    run_instr({6'b000011, 26'h0123456}, 32'h0040_000C, 1, 0, 3, 0);  // LW
    run_instr({6'b000100, 26'h0abcdef}, 32'h0000_000E, 0, 0, 2, 0);  // SW
    run_instr(32'h0822_1820, 32'h0040_0028, 0, 4, 0, 0);  // MUL
    run_instr({6'h3F, 26'h0}, 32'h0040_000E, 0, 0, 0, 0);  // illegal
    run_instr({6'b000100, 26'h0000011}, 32'h0000_000E, 0, 0, 1, 1);  // SW + stop
    chk("stop_idle", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));
    step();
    chk("stop_idle_hold", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));
    chk("stop_idle_pc", {24'd0, pc}, {24'd0, exp_pc});

    do_start();
    for (int n = 0; n < 72; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (op == 6'd2 || op == 6'd3 || op == 6'd4);
      end else begin
        op = 6'($urandom_range(2, 4));
      end
      ins = {op, 26'($urandom)};
      ctl = $urandom;
      if ($urandom_range(0, 3) == 0) ctl[5:3] = 3'b101;
      prev_pc = exp_pc;
      run_instr(ins, ctl, $urandom_range(0, 3), $urandom_range(0, 5),
                $urandom_range(0, 3), 0);
      if (prev_pc == 8'hFC) chk("pc_wrap", {24'd0, pc}, 32'd0);
    end

`ifdef CPU_SEQ_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, exp_retired);
`endif

    // Asynchronous reset while a MUL waits in EXEC.
    run_instr({6'b000100, 26'h0000022}, 32'h0000_000E, 0, 0, 0, 1);
    do_start();
    imem_rdata = 32'h0822_1820;
    imem_ack   = 1'b1;
    step();
    imem_ack = 1'b0;
    ctl_word = 32'h0040_0028;
    step();
    chk("pre_reset_exec", obs_vec(), mk_vec(1, 0, 0, 1, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_strobes", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));
    chk("async_reset_pc", {24'd0, pc}, 32'd0);
    chk("async_reset_instr", instr, 32'd0);
    chk("async_reset_ctl_q", ctl_q, 32'd0);
    alu_done = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_no_wb", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));
    end
    alu_done = 1'b0;
    $display("[TB] async reset during EXEC checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
